// File: rtl/cam_yuv_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_yuv_capture
// Purpose  : Samples an OV-style parallel camera bus in the system clock
//            domain and packs the YUYV byte stream into {V, Y1, U, Y0}
//            words, each tagged with word/line coordinates.
// Option   : CAM_CAPTURE_DECIMATE_EN - 2:1 decimation in both axes; only
//            even words of even lines are emitted, with halved coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module cam_yuv_capture #(
  parameter int H_WORDS     = 320,
  parameter int V_LINES     = 480,
  parameter int SYNC_STAGES = 2     // must be 2 or more
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_pclk,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic [7:0]  cam_data,
  output logic [31:0] yuv,
  output logic        yuv_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [9:0] c_H_MAX = 10'(H_WORDS);
  localparam logic [9:0] c_V_MAX = 10'(V_LINES);
  localparam int         c_SW    = 11;   // pclk + href + vsync + 8 data bits

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Synchronizer chain; index 0 is closest to the pins
  logic [SYNC_STAGES-1:0][c_SW-1:0] sync_q;
  logic [2:0]  prev_q;                  // previous synced {pclk, href, vsync}

  state_t      state_q;
  logic [1:0]  phase_q;
  logic [9:0]  word_q;
  logic [9:0]  line_q;
  logic        line_hit_q;              // a word was captured on this line
  logic        armed_q;                 // frame_start still owed this frame
  logic        frame_start_q;
  logic        sync_err_q;

  logic [23:0] asm_q;                   // bytes 0..2 of the word in progress
  logic        pend_q;
  logic [31:0] pend_word_q;
  logic [9:0]  pend_x_q;
  logic [9:0]  pend_y_q;
  logic        done_pend_q;

  logic [31:0] yuv_q;
  logic        yuv_valid_q;
  logic [9:0]  pix_x_q;
  logic [9:0]  pix_y_q;
  logic        frame_done_q;

  logic        w_pclk_s;
  logic        w_href_s;
  logic        w_vsync_s;
  logic [7:0]  w_data_s;
  logic        w_pclk_rise;
  logic        w_href_fall;
  logic        w_vsync_rise;
  logic        w_vsync_fall;
  logic        w_sample;
  logic        w_word_done;
  logic        w_in_bounds;
  logic        w_emit;
  logic [9:0]  w_x_out;
  logic [9:0]  w_y_out;

  assign {w_pclk_s, w_href_s, w_vsync_s, w_data_s} = sync_q[SYNC_STAGES-1];

  assign w_pclk_rise  =  w_pclk_s  & ~prev_q[2];
  assign w_href_fall  = ~w_href_s  &  prev_q[1];
  assign w_vsync_rise =  w_vsync_s & ~prev_q[0];
  assign w_vsync_fall = ~w_vsync_s &  prev_q[0];

  // A byte is taken only when the synced HREF is still high at the PCLK rise
  assign w_sample    = (state_q == ST_ACTIVE) & w_pclk_rise & w_href_s;
  assign w_word_done = w_sample & (phase_q == 2'd3);
  assign w_in_bounds = (word_q < c_H_MAX) & (line_q < c_V_MAX);

`ifdef CAM_CAPTURE_DECIMATE_EN
  assign w_emit  = ~word_q[0] & ~line_q[0];
  assign w_x_out = {1'b0, word_q[9:1]};
  assign w_y_out = {1'b0, line_q[9:1]};
`else
  assign w_emit  = 1'b1;
  assign w_x_out = word_q;
  assign w_y_out = line_q;
`endif

  // Bring all camera pins (data included) through an equal-depth flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cam_pclk, cam_href, cam_vsync, cam_data};
      prev_q <= {w_pclk_s, w_href_s, w_vsync_s};
    end
  end

  // Frame/line state machine, counters, frame_start and sticky sync_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= 2'd0;
      word_q        <= '0;
      line_q        <= '0;
      line_hit_q    <= 1'b0;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Wait for blanking so a frame already in flight is skipped
          if (w_vsync_s) state_q <= ST_BLANK;
        end
        ST_BLANK: begin
          if (w_vsync_fall) begin
            state_q    <= ST_ACTIVE;
            phase_q    <= 2'd0;
            word_q     <= '0;
            line_q     <= '0;
            line_hit_q <= 1'b0;
            armed_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_vsync_rise) begin
            // Frame ends; a line still open is aborted
            if (w_href_s || (phase_q != 2'd0)) sync_err_q <= 1'b1;
            state_q    <= ST_BLANK;
            phase_q    <= 2'd0;
            word_q     <= '0;
            line_hit_q <= 1'b0;
            armed_q    <= 1'b0;
          end else if (w_href_fall) begin
            if (phase_q != 2'd0) sync_err_q <= 1'b1;
            if (line_hit_q && (line_q != c_V_MAX)) line_q <= line_q + 10'd1;
            phase_q    <= 2'd0;
            word_q     <= '0;
            line_hit_q <= 1'b0;
          end else if (w_sample) begin
            armed_q <= 1'b0;
            if (armed_q) frame_start_q <= 1'b1;
            if (!w_in_bounds) sync_err_q <= 1'b1;
            phase_q <= phase_q + 2'd1;
            if (w_word_done) begin
              if (w_in_bounds) line_hit_q <= 1'b1;
              if (word_q != c_H_MAX) word_q <= word_q + 10'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Byte assembly; a finished word waits one clk before being presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      done_pend_q <= 1'b0;
    end else begin
      if (w_sample) begin
        case (phase_q)
          2'd0:    asm_q[7:0]   <= w_data_s;
          2'd1:    asm_q[15:8]  <= w_data_s;
          2'd2:    asm_q[23:16] <= w_data_s;
          default: ;
        endcase
      end
      pend_q <= w_word_done & w_in_bounds & w_emit;
      if (w_word_done && w_in_bounds && w_emit) begin
        pend_word_q <= {w_data_s, asm_q};
        pend_x_q    <= w_x_out;
        pend_y_q    <= w_y_out;
      end
      // frame_done shares the word path delay so both land on the same clk
      done_pend_q <= (state_q == ST_ACTIVE) & w_vsync_rise;
    end
  end

  // Output registers; word and coordinates hold until the next word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yuv_q        <= '0;
      yuv_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      yuv_valid_q  <= pend_q;
      frame_done_q <= done_pend_q;
      if (pend_q) begin
        yuv_q   <= pend_word_q;
        pix_x_q <= pend_x_q;
        pix_y_q <= pend_y_q;
      end
    end
  end

  assign yuv         = yuv_q;
  assign yuv_valid   = yuv_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire
